core_pipe_wb: RTL and testbench

- Writeback stage of the core pipeline; the consumer end of the execute stage's s3 interface.
- Accepts one retiring instruction at a time from execute.
- Waits for the data-memory or CSR response where the instruction needs one, then formats the result.
- Writes the GPR file, pulses instruction-retired, and reports traps (including late memory/CSR errors) to the trap/control-flow logic.

---
 rtl/core_pipe_wb_if.sv | 27 ++
 rtl/core_pipe_wb.sv | 207 ++++++++++++++++++++
 tb/tb_core_pipe_wb.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/core_pipe_wb_if.sv
// rtl/core_pipe_wb_if.sv - execute-to-writeback (s3) handshake bundle.
interface core_pipe_wb_if #(
   parameter int XLEN = 64
);
   logic            s3_valid;
   logic            s3_ready;
   logic [XLEN-1:0] s3_pc;
   logic [31:0]     s3_instr;
   logic [XLEN-1:0] s3_wdata;
   logic [4:0]      s3_rd;
   logic [4:0]      s3_lsu_op;
   logic [3:0]      s3_csr_op;
   logic [1:0]      s3_wb_op;
   logic            s3_trap;

   modport master (
      output s3_valid, s3_pc, s3_instr, s3_wdata, s3_rd,
             s3_lsu_op, s3_csr_op, s3_wb_op, s3_trap,
      input  s3_ready
   );

   modport slave (
      input  s3_valid, s3_pc, s3_instr, s3_wdata, s3_rd,
             s3_lsu_op, s3_csr_op, s3_wb_op, s3_trap,
      output s3_ready
   );
endinterface

// File: rtl/core_pipe_wb.sv
// rtl/core_pipe_wb.sv - pipeline writeback stage; CORE_WB_FWD_EN enables the decode bypass outputs.
module core_pipe_wb #(
   parameter int XLEN = 64
) (
   input  logic            g_clk,
   input  logic            g_resetn,
   core_pipe_wb_if.slave   s3,
   input  logic            dmem_rsp_valid,
   input  logic            dmem_rsp_error,
   input  logic [XLEN-1:0] dmem_rsp_rdata,
   output logic            csr_req_valid,
   output logic [3:0]      csr_req_op,
   output logic [11:0]     csr_req_addr,
   output logic [XLEN-1:0] csr_req_wdata,
   input  logic            csr_rsp_valid,
   input  logic            csr_rsp_error,
   input  logic [XLEN-1:0] csr_rsp_rdata,
   output logic            rf_wen,
   output logic [4:0]      rf_waddr,
   output logic [XLEN-1:0] rf_wdata,
   output logic            instr_ret,
   output logic            trap_valid,
   output logic [XLEN-1:0] trap_pc,
   output logic [1:0]      trap_cause,
   output logic            fwd_valid,
   output logic [4:0]      fwd_rd,
   output logic [XLEN-1:0] fwd_data
);

   localparam int XL = XLEN - 1;

   localparam logic [1:0] WB_WDATA = 2'b00;
   localparam logic [1:0] WB_LSU   = 2'b01;
   localparam logic [1:0] WB_CSR   = 2'b10;
   localparam logic [1:0] WB_NONE  = 2'b11;

   typedef enum logic {EMPTY, BUSY} state_t;

   state_t        state_q, state_d;
   logic [XL:0]   pc_q, pc_d;
   logic [XL:0]   wdata_q, wdata_d;
   logic [11:0]   csr_addr_q, csr_addr_d;
   logic [4:0]    rd_q, rd_d;
   logic [1:0]    lsu_width_q, lsu_width_d;
   logic          lsu_sext_q, lsu_sext_d;
   logic          lsu_store_q, lsu_store_d;
   logic [3:0]    csr_op_q, csr_op_d;
   logic [1:0]    wb_op_q, wb_op_d;
   logic          trap_q, trap_d;

   logic          busy;
   logic          done;
   logic          accept;
   logic          bus_err;
   logic          csr_err;
   logic          any_err;
   logic [2:0]    ld_off;
   logic [XL:0]   ld_lane;
   logic [XL:0]   ld_data;
   logic [XL:0]   wr_data;

   // Low instruction bits and the load flag are not needed once wb_op selects the path.
   logic          unused_s3;
   assign unused_s3 = ^{s3.s3_instr[19:0], s3.s3_lsu_op[0]};

   assign busy = (state_q == BUSY);

   always_comb begin
      done = 1'b0;
      if (busy) begin
         if (trap_q || wb_op_q == WB_WDATA || wb_op_q == WB_NONE)
            done = 1'b1;
         else if (wb_op_q == WB_LSU)
            done = dmem_rsp_valid;
         else
            done = csr_rsp_valid;
      end
   end

   assign s3.s3_ready = !busy || done;
   assign accept      = s3.s3_valid && s3.s3_ready;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      wdata_d     = wdata_q;
      csr_addr_d  = csr_addr_q;
      rd_d        = rd_q;
      lsu_width_d = lsu_width_q;
      lsu_sext_d  = lsu_sext_q;
      lsu_store_d = lsu_store_q;
      csr_op_d    = csr_op_q;
      wb_op_d     = wb_op_q;
      trap_d      = trap_q;
      if (accept) begin
         state_d     = BUSY;
         pc_d        = s3.s3_pc;
         wdata_d     = s3.s3_wdata;
         csr_addr_d  = s3.s3_instr[31:20];
         rd_d        = s3.s3_rd;
         lsu_width_d = s3.s3_lsu_op[4:3];
         lsu_sext_d  = s3.s3_lsu_op[2];
         lsu_store_d = s3.s3_lsu_op[1];
         csr_op_d    = s3.s3_csr_op;
         wb_op_d     = s3.s3_wb_op;
         trap_d      = s3.s3_trap;
      end else if (done) begin
         state_d = EMPTY;
      end
   end

   always_ff @(posedge g_clk) begin
      if (!g_resetn) begin
         state_q     <= EMPTY;
         pc_q        <= '0;
         wdata_q     <= '0;
         csr_addr_q  <= '0;
         rd_q        <= '0;
         lsu_width_q <= '0;
         lsu_sext_q  <= 1'b0;
         lsu_store_q <= 1'b0;
         csr_op_q    <= '0;
         wb_op_q     <= '0;
         trap_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         wdata_q     <= wdata_d;
         csr_addr_q  <= csr_addr_d;
         rd_q        <= rd_d;
         lsu_width_q <= lsu_width_d;
         lsu_sext_q  <= lsu_sext_d;
         lsu_store_q <= lsu_store_d;
         csr_op_q    <= csr_op_d;
         wb_op_q     <= wb_op_d;
         trap_q      <= trap_d;
      end
   end

   // Misaligned offsets are rounded down to the access size before lane selection.
   always_comb begin
      ld_off = 3'b000;
      case (lsu_width_q)
         2'b00:   ld_off = wdata_q[2:0];
         2'b01:   ld_off = {wdata_q[2:1], 1'b0};
         2'b10:   ld_off = {wdata_q[2], 2'b00};
         default: ld_off = 3'b000;
      endcase
   end

   assign ld_lane = dmem_rsp_rdata >> {ld_off, 3'b000};

   always_comb begin
      ld_data = ld_lane;
      case (lsu_width_q)
         2'b00:   ld_data = {{(XLEN-8){lsu_sext_q && ld_lane[7]}},   ld_lane[7:0]};
         2'b01:   ld_data = {{(XLEN-16){lsu_sext_q && ld_lane[15]}}, ld_lane[15:0]};
         2'b10:   ld_data = {{(XLEN-32){lsu_sext_q && ld_lane[31]}}, ld_lane[31:0]};
         default: ld_data = ld_lane;
      endcase
   end

   always_comb begin
      wr_data = wdata_q;
      case (wb_op_q)
         WB_LSU:  wr_data = ld_data;
         WB_CSR:  wr_data = csr_rsp_rdata;
         default: wr_data = wdata_q;
      endcase
   end

   assign bus_err = (wb_op_q == WB_LSU) && dmem_rsp_error;
   assign csr_err = (wb_op_q == WB_CSR) && csr_rsp_error;
   assign any_err = !trap_q && (bus_err || csr_err);

   assign rf_wen     = done && !trap_q && !any_err && (rd_q != 5'd0) && (wb_op_q != WB_NONE)
                       && !((wb_op_q == WB_LSU) && lsu_store_q);
   assign rf_waddr   = rf_wen ? rd_q : 5'd0;
   assign rf_wdata   = rf_wen ? wr_data : '0;
   assign instr_ret  = done && !trap_q && !any_err;
   assign trap_valid = done && (trap_q || any_err);
   assign trap_pc    = trap_valid ? pc_q : '0;

   always_comb begin
      trap_cause = 2'b00;
      if (trap_valid && !trap_q)
         trap_cause = bus_err ? 2'b01 : 2'b10;
   end

   // The request stays up through the response cycle; the fields come from held state so they cannot move.
   assign csr_req_valid = busy && (wb_op_q == WB_CSR) && !trap_q;
   assign csr_req_op    = csr_req_valid ? csr_op_q   : 4'd0;
   assign csr_req_addr  = csr_req_valid ? csr_addr_q : 12'd0;
   assign csr_req_wdata = csr_req_valid ? wdata_q    : '0;

`ifdef CORE_WB_FWD_EN
   assign fwd_valid = busy && (rd_q != 5'd0) && !trap_q
                      && ((wb_op_q == WB_WDATA) || (done && (wb_op_q == WB_LSU || wb_op_q == WB_CSR)));
   assign fwd_rd    = fwd_valid ? rd_q : 5'd0;
   assign fwd_data  = fwd_valid ? wr_data : '0;
`else
   assign fwd_valid = 1'b0;
   assign fwd_rd    = 5'd0;
   assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_core_pipe_wb.sv
// tb/tb_core_pipe_wb.sv - directed and randomized bench for core_pipe_wb against a behavioural model.
module tb_core_pipe_wb;
   localparam int XLEN = 64;

   logic        g_clk = 1'b0;
   logic        g_resetn;
   logic        dmem_rsp_valid, dmem_rsp_error;
   logic [63:0] dmem_rsp_rdata;
   logic        csr_req_valid;
   logic [3:0]  csr_req_op;
   logic [11:0] csr_req_addr;
   logic [63:0] csr_req_wdata;
   logic        csr_rsp_valid, csr_rsp_error;
   logic [63:0] csr_rsp_rdata;
   logic        rf_wen;
   logic [4:0]  rf_waddr;
   logic [63:0] rf_wdata;
   logic        instr_ret, trap_valid;
   logic [63:0] trap_pc;
   logic [1:0]  trap_cause;
   logic        fwd_valid;
   logic [4:0]  fwd_rd;
   logic [63:0] fwd_data;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 g_clk = ~g_clk;

   core_pipe_wb_if #(.XLEN(XLEN)) s3 ();

   core_pipe_wb #(.XLEN(XLEN)) dut (
      .g_clk(g_clk), .g_resetn(g_resetn), .s3(s3),
      .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_error(dmem_rsp_error), .dmem_rsp_rdata(dmem_rsp_rdata),
      .csr_req_valid(csr_req_valid), .csr_req_op(csr_req_op), .csr_req_addr(csr_req_addr),
      .csr_req_wdata(csr_req_wdata), .csr_rsp_valid(csr_rsp_valid), .csr_rsp_error(csr_rsp_error),
      .csr_rsp_rdata(csr_rsp_rdata), .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .instr_ret(instr_ret), .trap_valid(trap_valid), .trap_pc(trap_pc), .trap_cause(trap_cause),
      .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
   );

   // Model: the one instruction currently owned by writeback.
   logic        m_busy = 1'b0;
   logic [63:0] m_pc, m_wdata;
   logic [31:0] m_instr;
   logic [4:0]  m_rd, m_lsu;
   logic [3:0]  m_csr;
   logic [1:0]  m_wb;
   logic        m_trap;
   logic        e_done, e_ready;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s t=%0t actual=%h expected=%h", nm, $time, act, exp);
      end
   endtask

   function automatic logic [63:0] load_val(input logic [4:0] lsu, input logic [2:0] a, input logic [63:0] d);
      int n = 1 << lsu[4:3];
      int off = (int'(a) / n) * n;
      logic neg = lsu[2] && d[8*(off+n)-1];
      logic [63:0] v = '0;
      for (int i = 0; i < 8; i++) begin
         if (i < n) v[8*i +: 8] = d[8*(off+i) +: 8];
         else       v[8*i +: 8] = neg ? 8'hFF : 8'h00;
      end
      return v;
   endfunction

   task automatic eval();
      logic need_wait, got, err, e_wen, e_ret, e_trap, e_creq, e_fwd;
      logic [63:0] val;
      logic [1:0] cause;
      #2;
      need_wait = !m_trap && (m_wb == 2'd1 || m_wb == 2'd2);
      got       = (m_wb == 2'd1) ? dmem_rsp_valid : csr_rsp_valid;
      e_done    = m_busy && (!need_wait || got);
      e_ready   = !m_busy || e_done;
      err       = !m_trap && ((m_wb == 2'd1 && dmem_rsp_error) || (m_wb == 2'd2 && csr_rsp_error));
      e_wen     = e_done && !m_trap && !err && m_rd != 0 && m_wb != 2'd3 && !(m_wb == 2'd1 && m_lsu[1]);
      e_ret     = e_done && !m_trap && !err;
      e_trap    = e_done && (m_trap || err);
      cause     = m_trap ? 2'd0 : (m_wb == 2'd1) ? 2'd1 : 2'd2;
      val       = (m_wb == 2'd2) ? csr_rsp_rdata : (m_wb == 2'd1) ? load_val(m_lsu, m_wdata[2:0], dmem_rsp_rdata) : m_wdata;
      e_creq    = m_busy && m_wb == 2'd2 && !m_trap;
`ifdef CORE_WB_FWD_EN
      e_fwd     = m_busy && m_rd != 0 && !m_trap && (m_wb == 2'd0 || (e_done && (m_wb == 2'd1 || m_wb == 2'd2)));
`else
      e_fwd     = 1'b0;
`endif
      chk("s3_ready",   64'(s3.s3_ready), 64'(e_ready));
      chk("rf_wen",     64'(rf_wen), 64'(e_wen));
      chk("rf_waddr",   64'(rf_waddr), e_wen ? 64'(m_rd) : 64'd0);
      chk("rf_wdata",   rf_wdata, e_wen ? val : 64'd0);
      chk("instr_ret",  64'(instr_ret), 64'(e_ret));
      chk("trap_valid", 64'(trap_valid), 64'(e_trap));
      chk("trap_pc",    trap_pc, e_trap ? m_pc : 64'd0);
      chk("trap_cause", 64'(trap_cause), e_trap ? 64'(cause) : 64'd0);
      chk("csr_req_valid", 64'(csr_req_valid), 64'(e_creq));
      chk("csr_req_op",    64'(csr_req_op), e_creq ? 64'(m_csr) : 64'd0);
      chk("csr_req_addr",  64'(csr_req_addr), e_creq ? 64'(m_instr[31:20]) : 64'd0);
      chk("csr_req_wdata", csr_req_wdata, e_creq ? m_wdata : 64'd0);
      chk("fwd_valid",  64'(fwd_valid), 64'(e_fwd));
      chk("fwd_rd",     64'(fwd_rd), e_fwd ? 64'(m_rd) : 64'd0);
      chk("fwd_data",   fwd_data, e_fwd ? val : 64'd0);
   endtask

   task automatic tick();
      @(posedge g_clk);
      if (!g_resetn) begin
         m_busy = 1'b0;
      end else if (s3.s3_valid && e_ready) begin
         m_busy = 1'b1; m_pc = s3.s3_pc; m_instr = s3.s3_instr; m_wdata = s3.s3_wdata;
         m_rd = s3.s3_rd; m_lsu = s3.s3_lsu_op; m_csr = s3.s3_csr_op; m_wb = s3.s3_wb_op; m_trap = s3.s3_trap;
      end else if (e_done) begin
         m_busy = 1'b0;
      end
      #1;
   endtask

   task automatic idle();
      s3.s3_valid = 0; s3.s3_pc = 0; s3.s3_instr = 0; s3.s3_wdata = 0; s3.s3_rd = 0;
      s3.s3_lsu_op = 0; s3.s3_csr_op = 0; s3.s3_wb_op = 0; s3.s3_trap = 0;
      dmem_rsp_valid = 0; dmem_rsp_error = 0; dmem_rsp_rdata = 0;
      csr_rsp_valid = 0; csr_rsp_error = 0; csr_rsp_rdata = 0;
   endtask

   task automatic send(input logic [63:0] pc, input logic [31:0] ins, input logic [63:0] wd, input logic [4:0] rd,
                       input logic [4:0] lsu, input logic [3:0] csr, input logic [1:0] wb, input logic trap);
      s3.s3_valid = 1; s3.s3_pc = pc; s3.s3_instr = ins; s3.s3_wdata = wd; s3.s3_rd = rd;
      s3.s3_lsu_op = lsu; s3.s3_csr_op = csr; s3.s3_wb_op = wb; s3.s3_trap = trap;
   endtask

   initial begin
      m_pc = 0; m_wdata = 0; m_instr = 0; m_rd = 0; m_lsu = 0; m_csr = 0; m_wb = 0; m_trap = 0;
      e_done = 0; e_ready = 1;
      g_resetn = 0; idle();
      tick(); tick();
      g_resetn = 1;
      eval(); chk("rst_ready", 64'(s3.s3_ready), 1); chk("rst_wen", 64'(rf_wen), 0); chk("rst_trap", 64'(trap_valid), 0); tick();

      // ALU result, then rd=0 variant
      send(64'h100, 0, 64'h1234, 5, 0, 0, 2'b00, 0); eval(); tick(); idle();
      eval(); chk("alu_wen", 64'(rf_wen), 1); chk("alu_waddr", 64'(rf_waddr), 5);
      chk("alu_wdata", rf_wdata, 64'h1234); chk("alu_ret", 64'(instr_ret), 1); tick();
      send(64'h104, 0, 64'h55, 0, 0, 0, 2'b00, 0); eval(); tick(); idle();
      eval(); chk("rd0_wen", 64'(rf_wen), 0); chk("rd0_ret", 64'(instr_ret), 1); tick();

      // Signed byte load with a 4-cycle response delay, then unsigned
      send(64'h200, 0, 64'h3, 7, 5'b00101, 0, 2'b01, 0); eval(); tick(); idle();
      for (int i = 0; i < 4; i++) begin eval(); chk("ld_wait_ready", 64'(s3.s3_ready), 0); tick(); end
      dmem_rsp_valid = 1; dmem_rsp_rdata = 64'h0000_0000_80FF_0000;
      eval(); chk("lb_wen", 64'(rf_wen), 1); chk("lb_wdata", rf_wdata, 64'hFFFF_FFFF_FFFF_FF80); tick(); idle();
      send(64'h204, 0, 64'h3, 7, 5'b00001, 0, 2'b01, 0); eval(); tick(); idle();
      dmem_rsp_valid = 1; dmem_rsp_rdata = 64'h0000_0000_80FF_0000;
      eval(); chk("lbu_wdata", rf_wdata, 64'h80); tick(); idle();

      // Store with bus error
      send(64'h1000, 0, 64'h0, 9, 5'b11010, 0, 2'b01, 0); eval(); tick(); idle();
      dmem_rsp_valid = 1; dmem_rsp_error = 1;
      eval(); chk("st_wen", 64'(rf_wen), 0); chk("st_ret", 64'(instr_ret), 0); chk("st_trap", 64'(trap_valid), 1);
      chk("st_cause", 64'(trap_cause), 1); chk("st_pc", trap_pc, 64'h1000); tick(); idle();

      // CSR read of 0x300, then a CSR error
      send(64'h300, 32'h3000_2573, 64'h0, 10, 0, 4'b0010, 2'b10, 0); eval(); tick(); idle();
      for (int i = 0; i < 2; i++) begin
         eval(); chk("csr_req", 64'(csr_req_valid), 1); chk("csr_addr", 64'(csr_req_addr), 64'h300); tick();
      end
      csr_rsp_valid = 1; csr_rsp_rdata = 64'hA;
      eval(); chk("csr_wen", 64'(rf_wen), 1); chk("csr_wdata", rf_wdata, 64'hA); tick(); idle();
      send(64'h304, 32'h3000_2573, 64'h0, 10, 0, 4'b0010, 2'b10, 0); eval(); tick(); idle();
      csr_rsp_valid = 1; csr_rsp_error = 1;
      eval(); chk("csr_err_trap", 64'(trap_valid), 1); chk("csr_err_cause", 64'(trap_cause), 2); tick(); idle();

      // Three back-to-back ALU results
      for (int i = 0; i < 3; i++) begin
         send(64'h500 + 64'(4*i), 0, 64'h10 + 64'(i), 5'(i + 1), 0, 0, 2'b00, 0);
         eval(); chk("b2b_ready", 64'(s3.s3_ready), 1);
         if (i > 0) begin chk("b2b_wen", 64'(rf_wen), 1); chk("b2b_waddr", 64'(rf_waddr), 64'(i)); end
         tick();
      end
      idle(); eval(); chk("b2b_wen3", 64'(rf_wen), 1); chk("b2b_waddr3", 64'(rf_waddr), 3); tick();

      // Exec trap on a CSR op: no request, cause 00
      send(64'h400, 32'h3000_2573, 0, 4, 0, 4'b0010, 2'b10, 1); eval(); tick(); idle();
      eval(); chk("xt_req", 64'(csr_req_valid), 0); chk("xt_trap", 64'(trap_valid), 1);
      chk("xt_cause", 64'(trap_cause), 0); chk("xt_pc", trap_pc, 64'h400); tick();

      // Reset while waiting for a load; late response ignored
      send(64'h600, 0, 64'h0, 6, 5'b11001, 0, 2'b01, 0); eval(); tick(); idle();
      eval(); tick();
      g_resetn = 0; eval(); tick(); g_resetn = 1;
      eval(); chk("mrst_ready", 64'(s3.s3_ready), 1); chk("mrst_wen", 64'(rf_wen), 0); tick();
      dmem_rsp_valid = 1; dmem_rsp_rdata = 64'h1234;
      eval(); chk("late_wen", 64'(rf_wen), 0); chk("late_ret", 64'(instr_ret), 0); tick(); idle();

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         g_resetn       = ($urandom_range(0, 99) != 0);
         s3.s3_valid    = $urandom_range(0, 1);
         s3.s3_pc       = {$urandom, $urandom};
         s3.s3_instr    = $urandom;
         s3.s3_wdata    = {$urandom, $urandom};
         s3.s3_rd       = 5'($urandom);
         s3.s3_lsu_op   = 5'($urandom);
         s3.s3_csr_op   = 4'($urandom);
         s3.s3_wb_op    = 2'($urandom);
         s3.s3_trap     = ($urandom_range(0, 9) == 0);
         dmem_rsp_valid = ($urandom_range(0, 9) < 4);
         dmem_rsp_error = ($urandom_range(0, 6) == 0);
         dmem_rsp_rdata = {$urandom, $urandom};
         csr_rsp_valid  = ($urandom_range(0, 9) < 4);
         csr_rsp_error  = ($urandom_range(0, 6) == 0);
         csr_rsp_rdata  = {$urandom, $urandom};
         eval();
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
